// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural order using a ping-pong
// pair of N-entry register banks: one bank is filled while the other drains.
module fft_bitrev_reorder #(
  parameter int W    = 8,
  parameter int LOGN = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_im,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic [W-1:0] out_im,
  output logic         out_last,
  output logic         overflow
);

  localparam int N = 1 << LOGN;
  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high. in_ready is status only; a write while in_ready is low is dropped and
  // flagged in overflow. out_* hold stable while out_valid & ~out_ready.

  logic [2*W-1:0]  mem [2][N];
  logic            wbank;
  logic            rbank;
  logic [LOGN-1:0] wcnt;
  logic [LOGN-1:0] rcnt;
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic            overflow_q;

  logic            wr_fire;
  logic            rd_fire;
  logic            wr_done;
  logic            rd_done;
  logic [LOGN-1:0] wr_addr;
  logic [2*W-1:0]  rd_word;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] k);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = k[LOGN-1-i];
    end
    return r;
  endfunction

  assign in_ready  = ~full[wbank];
  assign out_valid = full[rbank];

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;
  assign wr_done = wr_fire & (wcnt == LAST_IDX);
  assign rd_done = rd_fire & (rcnt == LAST_IDX);
  assign wr_addr = bitrev(wcnt);

  assign rd_word  = mem[rbank][rcnt];
  assign out_r    = rd_word[2*W-1:W];
  assign out_im   = rd_word[W-1:0];
  assign out_last = out_valid & (rcnt == LAST_IDX);
  assign overflow = overflow_q;

  // Write and read always target different banks, so both updates can land in
  // the same cycle without conflict.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wbank] = 1'b1;
    if (rd_done) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (wr_fire) begin
      mem[wbank][wr_addr] <= {in_r, in_im};
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      full       <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wcnt <= wcnt + LOGN'(1);
        if (wr_done) wbank <= ~wbank;
      end
      if (in_valid & ~in_ready) overflow_q <= 1'b1;
      if (rd_fire) begin
        rcnt <= rcnt + LOGN'(1);
        if (rd_done) rbank <= ~rbank;
      end
    end
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

- Downstream stage of the radix-2 SDF FFT pipeline.
- Consumes quantized complex samples (real and imaginary parts, W bits each) that the last butterfly/delay stage produces in bit-reversed index order.
- Emits the same frame in natural order through a valid/ready output.
- Uses a ping-pong pair of N-entry register banks, so one frame is written while the previous frame is read.

## Interface

Parameters
- W, 8, width of each real/imaginary component (matches quantizer output).
- LOGN, 3, log2 of FFT length; N = 2^LOGN points per frame.

Ports
- clk  in  1  single clock; all state updates on rising edge.
- clear  in  1  asynchronous, active-low reset; when low, all state is forced to reset values immediately.
- in_valid  in  1  one input sample present this cycle.
- in_r  in  W  real part, two's complement.
- in_im  in  W  imaginary part, two's complement.
- in_ready  out  1  high when the current write bank can accept a sample (status only; upstream pipeline does not stall).
- out_valid  out  1  output sample available.
- out_ready  in  1  downstream accepts the output sample this cycle.
- out_r  out  W  real part, natural order.
- out_im  out  W  imaginary part, natural order.
- out_last  out  1  high with the sample of natural index N-1.
- overflow  out  1  sticky; set when a sample is dropped.

## Operation

- State:
  - mem[2][N] of 2W bits.
  - wbank, rbank: 1 bit each.
  - wcnt, rcnt: LOGN bits each.
  - full[1:0].
  - overflow.
- Write side:
  - in_ready = ~full[wbank].
  - Write fires on in_valid & in_ready: mem[wbank][bitrev(wcnt)] <= {in_r, in_im}; wcnt <= wcnt+1, wrapping at N.
  - On the write with wcnt == N-1: full[wbank] <= 1 and wbank toggles.
  - in_valid & ~in_ready: sample discarded; wcnt unchanged; overflow <= 1, cleared only by clear.
- bitrev(k): bit i of the address = bit LOGN-1-i of k.
- Read side:
  - out_valid = full[rbank].
  - {out_r, out_im} = mem[rbank][rcnt], combinational read of the register array.
  - out_last = out_valid & (rcnt == N-1).
  - Read fires on out_valid & out_ready: rcnt <= rcnt+1, wrapping at N.
  - On the read with rcnt == N-1: full[rbank] <= 0 and rbank toggles.
- While out_valid & ~out_ready, out_r, out_im and out_last hold stable.
- Simultaneous events:
  - A write completing one bank and a read completing the other bank in the same cycle both take effect; full bits update independently.
  - A read and a write never target the same bank, because the write bank is always non-full and the read bank is always full.
- No arithmetic: samples pass unmodified; W-bit values are never sign-extended or truncated.

## Timing

- Reset (clear low):
  - wbank, rbank, wcnt, rcnt, full and overflow go to 0.
  - mem is cleared to 0.
  - Outputs: out_valid=0, out_last=0, out_r=0, out_im=0, in_ready=1, overflow=0.
- Reset asserted mid-frame discards both banks, including a partially written frame. The first sample after release is treated as bit-reversed index 0.
- Latency: out_valid rises in the cycle after the Nth write of a frame is clocked. The first output is natural index 0.
- Throughput: one sample per cycle each side. Continuous input with out_ready held high never overflows.
- Overflow occurs only when both banks are full, i.e. the reader stalled for at least one full frame time.

## Test plan

- Single frame, N=8:
  - Stimulus: feed in_r = bitrev(k) for k=0..7 (values 0,4,2,6,1,5,3,7), in_im = 8'hF0 + k, with out_ready=1.
  - Required: out_valid rises one cycle after the 8th write. out_r reads 0,1,...,7 on consecutive cycles, with the matching in_im values. out_last is high only with out_r=7.
- Back-to-back frames:
  - Stimulus: 3 frames streamed continuously with out_ready=1.
  - Required: 24 outputs in order, no gaps after the first frame fills, overflow stays 0, banks alternate.
- Backpressure hold:
  - Stimulus: out_ready=0 for 5 cycles at natural index 3.
  - Required: out_r stays 3 and out_valid stays 1 throughout; the stream resumes with 4 once out_ready=1.
- Overflow:
  - Stimulus: out_ready=0; write 16 samples, then a 17th.
  - Required: in_ready=0 after the 16th sample, the 17th is dropped, overflow=1 and stays sticky. After out_ready=1, frame 1 is output intact.
- Reset mid-operation:
  - Stimulus: pull clear low after 5 writes of frame 2 while frame 1 is half read.
  - Required: out_valid=0, out_r=0, overflow=0 immediately. A fresh 8-sample frame after release is output correctly starting at index 0.
- Boundary overlap:
  - Stimulus: the 8th write of frame 2 and the last read of frame 1 occur in the same cycle.
  - Required: out_valid stays 1 in the next cycle with out_r = frame-2 index 0; no sample is lost.
